io_host_sequencer: RTL

Host-side initiator for the accelerator's pin-level IO port. It turns single-word commands into the cycle sequences the chip-side IO logic decodes: register shifts, memory write/read strobes, config shifts, monitor reads, and execution runs. It drives `io_opcode`/`in`, samples the 32-bit `out`, and runs the `reset_execution_io`/`enable_execution_io`/`done_execution_io` handshake. It sits in the FPGA/test-harness wrapper, between the host command FIFO and the chip pins.

---
 rtl/io_host_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/io_host_sequencer.sv
// Host-side initiator for the accelerator pin-level IO port: turns one command word into
// shift/issue/wait pin sequences or an execution run, and returns exactly one response.
module io_host_sequencer #(
   parameter int IN_L   = 8,
   parameter int REG_L  = 32,
   parameter int OPC_L  = 4,
   parameter logic [OPC_L-1:0] OPC_NOP   = OPC_L'(0),
   parameter logic [OPC_L-1:0] OPC_SHIFT = OPC_L'(1),
   parameter logic [OPC_L-1:0] OPC_WR    = OPC_L'(2),
   parameter logic [OPC_L-1:0] OPC_RD    = OPC_L'(3),
   parameter logic [OPC_L-1:0] OPC_CFG   = OPC_L'(4),
   parameter logic [OPC_L-1:0] OPC_MON   = OPC_L'(5),
   parameter int RD_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_vld,
   output logic             cmd_rdy,
   input  logic [2:0]       cmd_type,
   input  logic [REG_L-1:0] cmd_payload,
   output logic             rsp_vld,
   input  logic             rsp_rdy,
   output logic [31:0]      rsp_data,
   output logic             rsp_err,
   output logic [OPC_L-1:0] io_opcode,
   output logic [IN_L-1:0]  io_in,
   input  logic [31:0]      io_out,
   output logic             reset_execution_io,
   output logic             enable_execution_io,
   input  logic             done_execution_io
);

   // state    | meaning
   // IDLE     | waiting for a command, cmd_rdy high
   // SHIFT    | payload beats out on io_in, MSB beat first
   // ISSUE    | one WR/RD/CFG/MON opcode cycle
   // WAIT     | read latency, io_out captured in the last cycle
   // RUN_RST  | one-cycle reset_execution_io pulse
   // RUN_WAIT | enable high, counting until done or timeout
   // RESP     | response held until rsp_rdy
   typedef enum logic [2:0] {
      IDLE, SHIFT, ISSUE, WAIT, RUN_RST, RUN_WAIT, RESP
   } state_t;

   localparam int N_BEATS = REG_L / IN_L;
   localparam logic [31:0] BEAT_LAST = 32'(N_BEATS - 1);
   localparam logic [31:0] RD_LAST   = 32'(RD_LAT - 1);

   localparam logic [2:0] T_WRITE  = 3'd0;
   localparam logic [2:0] T_READ   = 3'd1;
   localparam logic [2:0] T_CONFIG = 3'd2;
   localparam logic [2:0] T_MON    = 3'd3;
   localparam logic [2:0] T_RUN    = 3'd4;

   state_t             state_q, state_d;
   logic [REG_L-1:0]   sr_q, sr_d;
   logic [2:0]         type_q, type_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_vld_q, rsp_vld_d;
   logic [OPC_L-1:0]   io_opcode_q, io_opcode_d;
   logic [IN_L-1:0]    io_in_q, io_in_d;
   logic               rst_exec_q, rst_exec_d;
   logic               en_exec_q, en_exec_d;

   logic [31:0]        cnt_inc;
   logic [31:0]        tmo;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
   // RUN never shifts, so the latched payload still holds the timeout
   assign tmo     = sr_q[31:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         type_q      <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_vld_q   <= 1'b0;
         io_opcode_q <= OPC_NOP;
         io_in_q     <= '0;
         rst_exec_q  <= 1'b0;
         en_exec_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         type_q      <= type_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_vld_q   <= rsp_vld_d;
         io_opcode_q <= io_opcode_d;
         io_in_q     <= io_in_d;
         rst_exec_q  <= rst_exec_d;
         en_exec_q   <= en_exec_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      type_d     = type_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (cmd_vld) begin
               sr_d   = cmd_payload;
               type_d = cmd_type;
               cnt_d  = '0;
               if (cmd_type == T_RUN) begin
                  state_d = RUN_RST;
               end else if (cmd_type > T_RUN) begin
                  state_d    = RESP;
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            sr_d = sr_q << IN_L;
            if (cnt_q == BEAT_LAST) begin
               state_d = ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ISSUE: begin
            rsp_err_d = 1'b0;
            case (type_q)
               T_WRITE: begin
                  rsp_data_d = '0;
                  state_d    = RESP;
               end
               T_READ: begin
                  cnt_d   = '0;
                  state_d = WAIT;
               end
               default: begin
                  rsp_data_d = io_out;
                  state_d    = RESP;
               end
            endcase
         end
         WAIT: begin
            if (cnt_q == RD_LAST) begin
               rsp_data_d = io_out;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RUN_RST: begin
            cnt_d   = '0;
            state_d = RUN_WAIT;
         end
         RUN_WAIT: begin
            cnt_d = cnt_inc;
            // done wins over a timeout landing in the same cycle
            if (done_execution_io) begin
               rsp_data_d = cnt_inc;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if ((tmo != 32'd0) && (cnt_inc == tmo)) begin
               rsp_data_d = tmo;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (rsp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      io_opcode_d = OPC_NOP;
      io_in_d     = '0;
      rst_exec_d  = 1'b0;
      en_exec_d   = 1'b0;
      rsp_vld_d   = 1'b0;
      case (state_d)
         SHIFT: begin
            io_opcode_d = OPC_SHIFT;
            io_in_d     = sr_d[REG_L-1 -: IN_L];
         end
         ISSUE: begin
            case (type_d)
               T_WRITE:  io_opcode_d = OPC_WR;
               T_READ:   io_opcode_d = OPC_RD;
               T_CONFIG: io_opcode_d = OPC_CFG;
               T_MON:    io_opcode_d = OPC_MON;
               default:  io_opcode_d = OPC_NOP;
            endcase
         end
         RUN_RST:  rst_exec_d = 1'b1;
         RUN_WAIT: en_exec_d  = 1'b1;
         RESP:     rsp_vld_d  = 1'b1;
         default:  io_opcode_d = OPC_NOP;
      endcase
   end

   assign cmd_rdy             = (state_q == IDLE);
   assign rsp_vld             = rsp_vld_q;
   assign rsp_data            = rsp_data_q;
   assign rsp_err             = rsp_err_q;
   assign io_opcode           = io_opcode_q;
   assign io_in               = io_in_q;
   assign reset_execution_io  = rst_exec_q;
   assign enable_execution_io = en_exec_q;

endmodule
